io_uart_tx: RTL



---
 rtl/io_pkg.sv | 28 ++
 rtl/io_sync_fifo.sv | 54 +++++
 rtl/io_uart_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared IO-space definitions: UART register offsets,
// STATUS bit positions and the transmitter state encoding.
package io_pkg;

   localparam logic [4:0] UART_TXDATA = 5'h00;
   localparam logic [4:0] UART_STATUS = 5'h01;
   localparam logic [4:0] UART_DIV    = 5'h02;
   localparam logic [4:0] UART_CTRL   = 5'h03;

   localparam int STAT_BUSY  = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_EMPTY = 2;
   localparam int STAT_OVF   = 3;
   localparam int STAT_CNT   = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uart_state_e;

   // A divisor of zero behaves as one clock per bit.
   function automatic logic [15:0] eff_div(input logic [15:0] d);
      return (d == 16'd0) ? 16'd1 : d;
   endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO, synchronous active-high reset.
// Ports: clock, reset, push/wr_data, pop/rd_data (head), full, empty, count.
module io_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Acceptance is judged on the count before any same-cycle pop.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MEM-stage IO bus.
// Ports: clock, reset, addr/wdata/io_we (bus), rdata (comb read), txd, irq.
module io_uart_tx
   import io_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RESET  = 434
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        io_we,
   output logic [31:0] rdata,
   output logic        txd,
   output logic        irq
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [4:0]  off;
   logic        sel;
   logic        wr_tx;
   logic        wr_st;
   logic        wr_div;
   logic        wr_ctl;

   logic [15:0] divisor;
   logic        enable;
   logic        irq_en;
   logic        ovf;

   logic          f_full;
   logic          f_empty;
   logic [CW-1:0] f_count;
   logic [7:0]    f_head;
   logic          pop;

   uart_state_e state_q;
   uart_state_e state_d;
   logic [15:0] baud_q;
   logic [15:0] baud_d;
   logic [2:0]  idx_q;
   logic [2:0]  idx_d;
   logic [7:0]  shreg_q;
   logic [7:0]  shreg_d;
   logic        bit_end;
   logic        busy;
   logic [31:0] status;

   logic unused;
   assign unused = ^{addr[31:8], addr[1:0], wdata[31:16]};

   assign sel    = addr[7];
   assign off    = addr[6:2];
   assign wr_tx  = io_we & sel & (off == UART_TXDATA);
   assign wr_st  = io_we & sel & (off == UART_STATUS);
   assign wr_div = io_we & sel & (off == UART_DIV);
   assign wr_ctl = io_we & sel & (off == UART_CTRL);

   // >= keeps a mid-bit divisor decrease from overrunning the bit.
   assign bit_end = (baud_q >= eff_div(divisor) - 16'd1);
   assign busy    = (state_q != S_IDLE);

   io_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (wr_tx),
      .wr_data (wdata[7:0]),
      .pop     (pop),
      .rd_data (f_head),
      .full    (f_full),
      .empty   (f_empty),
      .count   (f_count)
   );

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      txd     = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (enable && !f_empty) begin
               pop     = 1'b1;
               shreg_d = f_head;
               baud_d  = '0;
               idx_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            txd = 1'b0;
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_DATA: begin
            txd = shreg_q[idx_q];
            if (bit_end) begin
               baud_d = '0;
               idx_d  = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = S_STOP;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         divisor <= 16'(DIV_RESET);
         enable  <= 1'b0;
         irq_en  <= 1'b0;
         ovf     <= 1'b0;
         irq     <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         if (wr_div) divisor <= wdata[15:0];
         if (wr_ctl) begin
            enable <= wdata[0];
            irq_en <= wdata[1];
         end
         // A push into a full FIFO is lost even if a pop frees a slot.
         if (wr_tx && f_full) ovf <= 1'b1;
         else if (wr_st && wdata[STAT_OVF]) ovf <= 1'b0;
         irq <= irq_en & enable & f_empty & ~busy;
      end
   end

   always_comb begin
      status = '0;
      status[STAT_BUSY]       = busy;
      status[STAT_FULL]       = f_full;
      status[STAT_EMPTY]      = f_empty;
      status[STAT_OVF]        = ovf;
      status[STAT_CNT +: 5]   = 5'(f_count);
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         unique case (1'b1)
            (off == UART_STATUS): rdata = status;
            (off == UART_DIV):    rdata = {16'h0, divisor};
            (off == UART_CTRL):   rdata = {30'h0, irq_en, enable};
            default:              rdata = '0;
         endcase
      end
   end

endmodule
